// File: rtl/cpu_pkg.sv
// Shared definitions for the 5-stage MIPS core: opcodes, ALUOp encodings,
// control-bundle bit positions (shared with the ID/EX register) and the
// main control decoder.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // wb bundle
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  // m bundle
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;
  // ex bundle
  localparam int EX_REGDST   = 3;
  localparam int EX_ALUOP_HI = 2;
  localparam int EX_ALUOP_LO = 1;
  localparam int EX_ALUSRC   = 0;

  typedef struct packed {
    logic [1:0] wb;
    logic [1:0] m;
    logic [3:0] ex;
  } ctrl_t;

  // Main control decoder; unknown opcodes (and j) yield an all-zero bundle.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.wb[WB_REGWRITE]               = 1'b1;
        c.ex[EX_REGDST]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_FUNCT;
      end
      OP_ADDI: begin
        c.wb[WB_REGWRITE]               = 1'b1;
        c.ex[EX_ALUSRC]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
      end
      OP_LW: begin
        c.wb[WB_REGWRITE]               = 1'b1;
        c.wb[WB_MEMTOREG]               = 1'b1;
        c.m[M_MEMREAD]                  = 1'b1;
        c.ex[EX_ALUSRC]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
      end
      OP_SW: begin
        c.m[M_MEMWRITE]                 = 1'b1;
        c.ex[EX_ALUSRC]                 = 1'b1;
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_ADD;
      end
      OP_BEQ: begin
        c.ex[EX_ALUOP_HI:EX_ALUOP_LO]   = ALUOP_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detector: stalls the ID stage when the load sitting in
// ID/EX writes a register that the held instruction reads. $0 never stalls.
module hazard_unit (
  input  logic       valid_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] rs_i,
  input  logic [4:0] rt_i,
  output logic       stall_o
);

  // Pure combinational compare against both source fields.
  always_comb begin
    stall_o = valid_i & idex_memread_i & (idex_rt_i != 5'd0) &
              ((idex_rt_i == rs_i) | (idex_rt_i == rt_i));
  end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register plus instruction decode. Holds the fetched
// instruction and PC+4, produces the WB/M/EX control bundles, inserts a
// bubble on load-use hazards and resolves beq/j in ID (redirect + flush).
// Optional macro HAZARD_STATS_EN adds stall/flush event counters.
module if_id_stage
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc4_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic [31:0] pc4_o,
  output logic [1:0]  wb_o,
  output logic [1:0]  m_o,
  output logic [3:0]  ex_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic [31:0] pc_target_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  logic [31:0] pc4_q, pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;

  logic        stall;
  logic        live;
  logic [5:0]  op;
  ctrl_t       ctrl;
  logic        beq_taken;
  logic        jump;
  logic [31:0] br_target;
  logic [31:0] j_target;

  hazard_unit u_hazard (
    .valid_i        (valid_q),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .rs_i           (rs_o),
    .rt_i           (rt_o),
    .stall_o        (stall)
  );

  // Field extraction from the held instruction.
  always_comb begin
    op    = inst_q[31:26];
    rs_o  = inst_q[25:21];
    rt_o  = inst_q[20:16];
    rd_o  = inst_q[15:11];
    imm_o = {{16{inst_q[15]}}, inst_q[15:0]};
    pc4_o = pc4_q;
  end

  // Control decode; a flushed slot or a stall sends a bubble to ID/EX.
  always_comb begin
    live = valid_q & ~stall;
    ctrl = decode_ctrl(op);
    if (!live) begin
      ctrl = '0;
    end
    wb_o = ctrl.wb;
    m_o  = ctrl.m;
    ex_o = ctrl.ex;
  end

  // Branch/jump resolution; target defaults to the beq target when idle.
  always_comb begin
    br_target   = pc4_q + {imm_o[29:0], 2'b00};
    j_target    = {pc4_q[31:28], inst_q[25:0], 2'b00};
    beq_taken   = live & (op == OP_BEQ) & (rs_data_i == rt_data_i);
    jump        = live & (op == OP_J);
    pc_src_o    = beq_taken | jump;
    pc_target_o = jump ? j_target : br_target;
    pc_write_o  = ~stall;
  end

  // Next-state for IF/ID: stall holds, redirect flushes, otherwise load.
  always_comb begin
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (stall) begin
      pc4_d   = pc4_q;
    end else if (pc_src_o) begin
      pc4_d   = '0;
      inst_d  = '0;
      valid_d = 1'b0;
    end else begin
      pc4_d   = pc4_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end
  end

  // IF/ID register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc4_q   <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Event counters wrap naturally at 2^32.
  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, stall};
    flush_cnt_d = flush_cnt_q + {31'd0, pc_src_o};
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: a directed vector table followed by randomized
// traffic checked against a behavioural model of the ID stage.
module tb_if_id_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] pc4_i, inst_i, rs_data_i, rt_data_i;
  logic        idex_memread_i;
  logic [4:0]  idex_rt_i;
  logic [4:0]  rs_o, rt_o, rd_o;
  logic [31:0] imm_o, pc4_o, pc_target_o;
  logic [1:0]  wb_o, m_o;
  logic [3:0]  ex_o;
  logic        pc_write_o, pc_src_o;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  if_id_stage dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .pc4_i          (pc4_i),
    .inst_i         (inst_i),
    .rs_data_i      (rs_data_i),
    .rt_data_i      (rt_data_i),
    .idex_memread_i (idex_memread_i),
    .idex_rt_i      (idex_rt_i),
    .rs_o           (rs_o),
    .rt_o           (rt_o),
    .rd_o           (rd_o),
    .imm_o          (imm_o),
    .pc4_o          (pc4_o),
    .wb_o           (wb_o),
    .m_o            (m_o),
    .ex_o           (ex_o),
    .pc_write_o     (pc_write_o),
    .pc_src_o       (pc_src_o),
    .pc_target_o    (pc_target_o)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic [31:0] rsd;
    logic [31:0] rtd;
    logic        mr;
    logic [4:0]  irt;
    logic [1:0]  wb;
    logic [1:0]  m;
    logic [3:0]  ex;
    logic        pcw;
    logic        src;
    logic [31:0] tgt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] pc4o;
    logic        chkpc;
  } vec_t;

  localparam int NV = 15;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [31:0] pc4, input logic [31:0] inst,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic mr, input logic [4:0] irt);
    rst_i          = rst;
    pc4_i          = pc4;
    inst_i         = inst;
    rs_data_i      = rsd;
    rt_data_i      = rtd;
    idex_memread_i = mr;
    idex_rt_i      = irt;
  endtask

  // Random instruction, registers kept in $0..$3 to provoke hazards.
  function automatic logic [31:0] rand_inst();
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic [15:0] low;
    int k;
    k   = $urandom_range(0, 7);
    rs  = 5'($urandom_range(0, 3));
    rt  = 5'($urandom_range(0, 3));
    low = 16'($urandom);
    case (k)
      0, 1: op = 6'b000000;
      2:    op = 6'b001000;
      3:    op = 6'b100011;
      4:    op = 6'b101011;
      5:    op = 6'b000100;
      6:    op = 6'b000010;
      default: op = 6'($urandom);
    endcase
    return {op, rs, rt, low};
  endfunction

  // Behavioural model state
  logic        m_known, m_valid, m_pc_known;
  logic [31:0] m_inst, m_pc4;
  int unsigned m_stalls, m_flushes;

  initial begin
    //                rst   pc4           inst          rsd    rtd    mr    irt    wb     m      ex      pcw   src   tgt           rs     rt     rd      imm           pc4o          chk
    vt[0]  = '{1'b0, 32'h4,        32'h8C220004, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b1};
    vt[1]  = '{1'b0, 32'h8,        32'h00441820, 32'd0, 32'd0, 1'b0, 5'd0, 2'b11, 2'b10, 4'b0001, 1'b1, 1'b0, 32'h14,       5'd1, 5'd2, 5'd0,  32'h4,        32'h4,        1'b1};
    vt[2]  = '{1'b0, 32'hC,        32'h0,        32'd0, 32'd0, 1'b1, 5'd2, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 32'h6088,     5'd2, 5'd4, 5'd3,  32'h1820,     32'h8,        1'b1};
    vt[3]  = '{1'b0, 32'h10,       32'h1021FFFF, 32'd0, 32'd0, 1'b0, 5'd2, 2'b10, 2'b00, 4'b1100, 1'b1, 1'b0, 32'h6088,     5'd2, 5'd4, 5'd3,  32'h1820,     32'h8,        1'b1};
    vt[4]  = '{1'b0, 32'h14,       32'h8C220004, 32'd5, 32'd5, 1'b0, 5'd0, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b1, 32'hC,        5'd1, 5'd1, 5'd31, 32'hFFFFFFFF, 32'h10,       1'b1};
    vt[5]  = '{1'b0, 32'h18,       32'h1021FFFF, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b0};
    vt[6]  = '{1'b0, 32'h80000004, 32'h08000040, 32'd1, 32'd2, 1'b0, 5'd0, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0, 32'h14,       5'd1, 5'd1, 5'd31, 32'hFFFFFFFF, 32'h18,       1'b1};
    vt[7]  = '{1'b0, 32'h80000008, 32'h8C220004, 32'd0, 32'd0, 1'b0, 5'd0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1, 32'h80000100, 5'd0, 5'd0, 5'd0,  32'h40,       32'h80000004, 1'b1};
    vt[8]  = '{1'b0, 32'h20,       32'h00041820, 32'd0, 32'd0, 1'b1, 5'd0, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b0};
    vt[9]  = '{1'b0, 32'h24,       32'h00441820, 32'd0, 32'd0, 1'b1, 5'd0, 2'b10, 2'b00, 4'b1100, 1'b1, 1'b0, 32'h60A0,     5'd0, 5'd4, 5'd3,  32'h1820,     32'h20,       1'b1};
    vt[10] = '{1'b0, 32'h28,       32'h0,        32'd0, 32'd0, 1'b1, 5'd4, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 32'h60A4,     5'd2, 5'd4, 5'd3,  32'h1820,     32'h24,       1'b1};
    vt[11] = '{1'b1, 32'h28,       32'h0,        32'd0, 32'd0, 1'b1, 5'd4, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 32'h60A4,     5'd2, 5'd4, 5'd3,  32'h1820,     32'h24,       1'b1};
    vt[12] = '{1'b0, 32'h40,       32'h10420002, 32'd0, 32'd0, 1'b1, 5'd4, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 32'h0,        5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        1'b1};
    vt[13] = '{1'b0, 32'h44,       32'h0,        32'd7, 32'd7, 1'b1, 5'd2, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 32'h48,       5'd2, 5'd2, 5'd0,  32'h2,        32'h40,       1'b1};
    vt[14] = '{1'b0, 32'h44,       32'h0,        32'd7, 32'd7, 1'b0, 5'd2, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b1, 32'h48,       5'd2, 5'd2, 5'd0,  32'h2,        32'h40,       1'b1};

    drive(1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    repeat (2) @(posedge clk_i);

    // Directed sequence
    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      drive(vt[i].rst, vt[i].pc4, vt[i].inst, vt[i].rsd, vt[i].rtd, vt[i].mr, vt[i].irt);
      #1;
      chk($sformatf("v%0d wb", i),       32'(wb_o),       32'(vt[i].wb));
      chk($sformatf("v%0d m", i),        32'(m_o),        32'(vt[i].m));
      chk($sformatf("v%0d ex", i),       32'(ex_o),       32'(vt[i].ex));
      chk($sformatf("v%0d pc_write", i), 32'(pc_write_o), 32'(vt[i].pcw));
      chk($sformatf("v%0d pc_src", i),   32'(pc_src_o),   32'(vt[i].src));
      chk($sformatf("v%0d rs", i),       32'(rs_o),       32'(vt[i].rs));
      chk($sformatf("v%0d rt", i),       32'(rt_o),       32'(vt[i].rt));
      chk($sformatf("v%0d rd", i),       32'(rd_o),       32'(vt[i].rd));
      chk($sformatf("v%0d imm", i),      imm_o,           vt[i].imm);
      if (vt[i].chkpc) begin
        chk($sformatf("v%0d pc4", i),    pc4_o,           vt[i].pc4o);
        chk($sformatf("v%0d target", i), pc_target_o,     vt[i].tgt);
      end
    end

    // Randomized traffic against the behavioural model
    m_known    = 1'b0;
    m_valid    = 1'b0;
    m_pc_known = 1'b0;
    m_inst     = '0;
    m_pc4      = '0;
    m_stalls   = 0;
    m_flushes  = 0;
    for (int c = 0; c < 600; c++) begin
      logic [31:0] rsd, rtd, e_imm, e_tgt;
      logic [5:0]  e_op;
      logic [4:0]  e_rs, e_rt, e_rd;
      logic [7:0]  e_ctl;
      logic        e_stall, e_live, e_taken, e_jump;

      @(negedge clk_i);
      rsd = $urandom;
      rtd = ($urandom_range(0, 1) == 1) ? rsd : $urandom;
      drive((c == 0) || ($urandom_range(0, 39) == 0),
            $urandom & 32'hFFFF_FFFC, rand_inst(), rsd, rtd,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
      #1;

      e_op    = m_inst[31:26];
      e_rs    = m_inst[25:21];
      e_rt    = m_inst[20:16];
      e_rd    = m_inst[15:11];
      e_imm   = 32'($signed(m_inst[15:0]));
      e_stall = m_valid && idex_memread_i && (idex_rt_i != 0) &&
                (idex_rt_i == e_rs || idex_rt_i == e_rt);
      e_live  = m_valid && !e_stall;
      // {RegWrite,MemtoReg, MemRead,MemWrite, RegDst,ALUOp[1:0],ALUSrc}
      case (e_op)
        6'd0:  e_ctl = 8'b10_00_1100;
        6'd8:  e_ctl = 8'b10_00_0001;
        6'd35: e_ctl = 8'b11_10_0001;
        6'd43: e_ctl = 8'b00_01_0001;
        6'd4:  e_ctl = 8'b00_00_0010;
        default: e_ctl = 8'b00_00_0000;
      endcase
      if (!e_live) e_ctl = 8'd0;
      e_jump  = e_live && (e_op == 6'd2);
      e_taken = e_jump || (e_live && (e_op == 6'd4) && (rsd == rtd));
      e_tgt   = e_jump ? {m_pc4[31:28], m_inst[25:0], 2'b00} : m_pc4 + e_imm * 4;

      if (m_known) begin
        chk("r wb",       32'(wb_o),       32'(e_ctl[7:6]));
        chk("r m",        32'(m_o),        32'(e_ctl[5:4]));
        chk("r ex",       32'(ex_o),       32'(e_ctl[3:0]));
        chk("r pc_write", 32'(pc_write_o), 32'(!e_stall));
        chk("r pc_src",   32'(pc_src_o),   32'(e_taken));
        chk("r rs",       32'(rs_o),       32'(e_rs));
        chk("r rt",       32'(rt_o),       32'(e_rt));
        chk("r rd",       32'(rd_o),       32'(e_rd));
        chk("r imm",      imm_o,           e_imm);
        if (m_pc_known) begin
          chk("r pc4",    pc4_o,           m_pc4);
          chk("r target", pc_target_o,     e_tgt);
        end
      end
`ifdef HAZARD_STATS_EN
      if (c == 0) begin
        chk("stats stall after table", stall_cnt_o, 32'd1);
        chk("stats flush after table", flush_cnt_o, 32'd1);
      end else if (m_known) begin
        chk("stats stall", stall_cnt_o, m_stalls);
        chk("stats flush", flush_cnt_o, m_flushes);
      end
`endif

      @(posedge clk_i);
      if (rst_i) begin
        m_known    = 1'b1;
        m_valid    = 1'b0;
        m_inst     = '0;
        m_pc4      = '0;
        m_pc_known = 1'b1;
        m_stalls   = 0;
        m_flushes  = 0;
      end else if (e_stall) begin
        m_stalls++;
      end else if (e_taken) begin
        m_flushes++;
        m_valid    = 1'b0;
        m_inst     = '0;
        m_pc_known = 1'b0;
      end else begin
        m_valid    = 1'b1;
        m_inst     = inst_i;
        m_pc4      = pc4_i;
        m_pc_known = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

IF/ID pipeline register and instruction-decode stage of the 5-stage MIPS core. It latches the fetched instruction and PC+4, and decodes the WB/M/EX control bundles that feed the ID/EX register. It also detects load-use hazards (stall and bubble) and resolves beq/j in ID, redirecting fetch and flushing the fetch slot.

## Interface
Parameters:
- none.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; **synchronous, active-high**.
- pc4_i  in  32  PC+4 from fetch adder.
- inst_i  in  32  fetched instruction.
- rs_data_i / rt_data_i  in  32  register-file read data for rs_o/rt_o.
- idex_memread_i  in  1  MemRead currently held in ID/EX.
- idex_rt_i  in  5  destination rt currently held in ID/EX.
- rs_o / rt_o / rd_o  out  5  fields of the held instruction (also the register-file read addresses).
- imm_o  out  32  sign-extended inst[15:0].
- pc4_o  out  32  held PC+4.
- wb_o  out  2  [1]=RegWrite, [0]=MemtoReg.
- m_o  out  2  [1]=MemRead, [0]=MemWrite.
- ex_o  out  4  [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc.
- pc_write_o  out  1  0 = PC holds.
- pc_src_o  out  1  1 = fetch takes pc_target_o.
- pc_target_o  out  32  branch or jump target.

## Operation
- IF/ID state: pc4_q, inst_q, valid_q. wb_o/m_o/ex_o are combinational from inst_q, forced to 0 when !valid_q or stall.
- Decode:
  - R-type (op 000000): RegWrite=1, RegDst=1, ALUOp=10.
  - addi (001000): RegWrite=1, ALUSrc=1, ALUOp=00.
  - lw (100011): RegWrite=1, MemtoReg=1, MemRead=1, ALUSrc=1, ALUOp=00.
  - sw (101011): MemWrite=1, ALUSrc=1, ALUOp=00.
  - beq (000100): ALUOp=01.
  - j (000010): all controls 0.
  - Any other opcode: all controls 0.
- Load-use stall: stall = valid_q & idex_memread_i & (idex_rt_i != 0) & (idex_rt_i == rs_o | idex_rt_i == rt_o). When stall is asserted:
  - pc_write_o=0.
  - IF/ID holds.
  - Control outputs are zero, so the bubble enters ID/EX.
- Branch/jump: resolved only when valid_q & !stall.
  - beq taken: rs_data_i == rt_data_i. Target = pc4_q + (imm_o << 2), mod 2^32.
  - j: target = {pc4_q[31:28], inst_q[25:0], 2'b00}.
  - Either case asserts pc_src_o=1 and flushes. On the next edge valid_q=0 and inst_q=0, discarding the instruction in IF.
- pc_target_o is valid only when pc_src_o=1. Outside that case it shows the beq target.
- Priority: rst_i > stall > flush > normal load.

## Timing
- Reset, at the edge with rst_i=1: pc4_q=0, inst_q=0, valid_q=0. Consequently wb_o=m_o=ex_o=0, pc_src_o=0, pc_write_o=1, imm_o=0, rs_o=rt_o=rd_o=0, pc4_o=0.
- Reset asserted mid-stall or mid-flush drops the held instruction. There is no stall in the first cycle after reset.
- Latency: an instruction presented at edge N is decoded during cycle N+1.
- Stall lasts exactly 1 cycle per load-use pair, because ID/EX receives the bubble and the hazard clears.
- A taken branch costs 1 bubble. A beq whose operand is the pending load stalls first and resolves in the following cycle.
- A flushed slot (valid_q=0) never stalls, never branches, and outputs zero controls.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds outputs stall_cnt_o[31:0] and flush_cnt_o[31:0].
  - stall_cnt_o increments each cycle stall=1; flush_cnt_o increments each cycle pc_src_o=1.
  - Both wrap at 2^32 and clear on rst_i.
- Undefined: the ports and counters do not exist and behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg holds:
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J;
  - ALUOp encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10;
  - bit-index constants for the wb/m/ex bundles, shared with the ID/EX register.
- One sub-module: hazard_unit, combinational, producing stall from rs/rt/idex_rt/idex_memread/valid. The register and decode logic stay in the top module.

## Test plan
- Reset then lw $2,4($1) (0x8C220004) with pc4_i=0x4 → next cycle wb_o=11, m_o=10, ex_o=0001, rt_o=2, imm_o=4, pc4_o=0x4.
- idex_memread_i=1, idex_rt_i=2, held add $3,$2,$4 → pc_write_o=0, controls 0, IF/ID unchanged next cycle. With idex_memread_i=0 the next cycle gives wb_o=10, ex_o=1100.
- beq $1,$1,-1 at pc4_q=0x10 with equal data → pc_src_o=1, pc_target_o=0x0C, valid_q=0 next cycle. With unequal data → pc_src_o=0.
- j 0x0000040 at pc4_q=0x80000004 → pc_target_o=0x80000100, pc_src_o=1.
- Hazard with idex_rt_i=0 → no stall. rst_i asserted during a stall → all outputs at reset values next cycle.
- HAZARD_STATS_EN defined: 3 load-use pairs + 2 taken branches → stall_cnt_o=3, flush_cnt_o=2.
